// File: rtl/pipelined_carry_select_adder_if.sv
// Operand/result bus of the pipelined carry-select adder.
// Handshake: a beat moves across a side on a rising edge where that side's
// valid and ready are both high. in_ready depends only on out_valid and
// out_ready. While out_valid is high and out_ready is low, sum/cout/ovf
// hold their values.
interface pipelined_carry_select_adder_if #(
   parameter int N = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] sum;
   logic         cout;
   logic         ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor. Operands are cut into B-bit
// segments; stage k resolves segment k by choosing between its carry-0 and
// carry-1 sums with the carry registered by stage k-1. Raw operand bits of
// the segments that are still unresolved travel down the pipe with the beat.
// A single global stall freezes every stage when the output is blocked.
module pipelined_carry_select_adder #(
   parameter int N = 16,
   parameter int B = 4
) (
   input  logic clk,
   input  logic rst_n,
   pipelined_carry_select_adder_if.slave bus
);
   localparam int S = (N + B - 1) / B;

   logic         stall;
   logic [N-1:0] bx;
   logic         c0;

   assign stall       = bus.out_valid & ~bus.out_ready;
   assign bus.in_ready = ~stall;
   // Subtraction is a + ~b + 1, so cin is ignored in that mode.
   assign bx = bus.sub ? ~bus.b : bus.b;
   assign c0 = bus.sub | bus.cin;

   for (genvar k = 0; k < S; k++) begin : stg
      localparam int LO  = k * B;
      localparam int W   = (k == S - 1) ? N - LO : B;
      localparam int HI  = LO + W;
      localparam int RAW = N - HI;

      logic [W-1:0]  sa;
      logic [W-1:0]  sb;
      logic          ci;
      logic          vi;
      logic [W:0]    r0;
      logic [W:0]    r1;
      logic [W:0]    r;
      logic [HI-1:0] sum_d;
      logic [HI-1:0] sum_q;
      logic          c_q;
      logic          v_q;

      if (k == 0) begin : g_src
         assign sa    = bus.a[W-1:0];
         assign sb    = bx[W-1:0];
         assign ci    = c0;
         assign vi    = bus.in_valid;
         assign sum_d = r[W-1:0];
      end else begin : g_src
         assign sa    = stg[k-1].g_raw.a_q[W-1:0];
         assign sb    = stg[k-1].g_raw.b_q[W-1:0];
         assign ci    = stg[k-1].c_q;
         assign vi    = stg[k-1].v_q;
         assign sum_d = {r[W-1:0], stg[k-1].sum_q};
      end

      // Both carry hypotheses are ripple-summed; the incoming carry only drives the mux.
      assign r0 = {1'b0, sa} + {1'b0, sb};
      assign r1 = {1'b0, sa} + {1'b0, sb} + (W + 1)'(1);
      assign r  = ci ? r1 : r0;

      // Stage register: valid, resolved low sum bits and this segment's carry out.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q   <= 1'b0;
            c_q   <= 1'b0;
            sum_q <= '0;
         end else if (!stall) begin
            v_q   <= vi;
            c_q   <= r[W];
            sum_q <= sum_d;
         end
      end

      if (RAW > 0) begin : g_raw
         logic [RAW-1:0] a_d;
         logic [RAW-1:0] b_d;
         logic [RAW-1:0] a_q;
         logic [RAW-1:0] b_q;

         if (k == 0) begin : g_ld
            assign a_d = bus.a[N-1:HI];
            assign b_d = bx[N-1:HI];
         end else begin : g_ld
            assign a_d = stg[k-1].g_raw.a_q[N-LO-1:W];
            assign b_d = stg[k-1].g_raw.b_q[N-LO-1:W];
         end

         // Carry the unresolved operand bits forward, aligned to bit 0.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (!stall) begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end

      if (k == S - 1) begin : g_msb
         logic cm_q;

         // Carry into bit N-1, recovered from the MSB sum bit and its operands.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cm_q <= 1'b0;
            end else if (!stall) begin
               cm_q <= r[W-1] ^ sa[W-1] ^ sb[W-1];
            end
         end
      end
   end

   assign bus.out_valid = stg[S-1].v_q;
   assign bus.sum       = stg[S-1].sum_q;
   assign bus.cout      = stg[S-1].c_q;
   assign bus.ovf       = stg[S-1].g_msb.cm_q ^ stg[S-1].c_q;
endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Bench for pipelined_carry_select_adder: five instances cover the widths
// and segmentations of interest; one shared driver is steered to the
// instance chosen by sel and the chosen instance's outputs are muxed back.
module tb_pipelined_carry_select_adder;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   int          sel;
   logic        drv_valid;
   logic        drv_cin;
   logic        drv_sub;
   logic        drv_ordy;
   logic [15:0] drv_a;
   logic [15:0] drv_b;

   logic        mon_valid;
   logic        mon_irdy;
   logic        mon_cout;
   logic        mon_ovf;
   logic [15:0] mon_sum;

   int n_cmp = 0;
   int n_bad = 0;
   logic [17:0] exp_q[$];

   pipelined_carry_select_adder_if #(.N(8))  if_a ();
   pipelined_carry_select_adder_if #(.N(7))  if_b ();
   pipelined_carry_select_adder_if #(.N(16)) if_c ();
   pipelined_carry_select_adder_if #(.N(8))  if_d ();
   pipelined_carry_select_adder_if #(.N(4))  if_e ();

   pipelined_carry_select_adder #(.N(8),  .B(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
   pipelined_carry_select_adder #(.N(7),  .B(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
   pipelined_carry_select_adder #(.N(16), .B(4)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));
   pipelined_carry_select_adder #(.N(8),  .B(2)) u_d (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));
   pipelined_carry_select_adder #(.N(4),  .B(4)) u_e (.clk(clk), .rst_n(rst_n), .bus(if_e.slave));

   // ---------------- clock/reset and driver steering ----------------
   assign if_a.in_valid = drv_valid && (sel == 0);
   assign if_b.in_valid = drv_valid && (sel == 1);
   assign if_c.in_valid = drv_valid && (sel == 2);
   assign if_d.in_valid = drv_valid && (sel == 3);
   assign if_e.in_valid = drv_valid && (sel == 4);
   assign if_a.out_ready = (sel == 0) ? drv_ordy : 1'b1;
   assign if_b.out_ready = (sel == 1) ? drv_ordy : 1'b1;
   assign if_c.out_ready = (sel == 2) ? drv_ordy : 1'b1;
   assign if_d.out_ready = (sel == 3) ? drv_ordy : 1'b1;
   assign if_e.out_ready = (sel == 4) ? drv_ordy : 1'b1;
   assign if_a.a = drv_a[7:0];  assign if_a.b = drv_b[7:0];
   assign if_b.a = drv_a[6:0];  assign if_b.b = drv_b[6:0];
   assign if_c.a = drv_a;       assign if_c.b = drv_b;
   assign if_d.a = drv_a[7:0];  assign if_d.b = drv_b[7:0];
   assign if_e.a = drv_a[3:0];  assign if_e.b = drv_b[3:0];
   assign if_a.cin = drv_cin;   assign if_a.sub = drv_sub;
   assign if_b.cin = drv_cin;   assign if_b.sub = drv_sub;
   assign if_c.cin = drv_cin;   assign if_c.sub = drv_sub;
   assign if_d.cin = drv_cin;   assign if_d.sub = drv_sub;
   assign if_e.cin = drv_cin;   assign if_e.sub = drv_sub;

   // Observe the currently selected instance.
   always_comb begin
      mon_valid = 1'b0;
      mon_irdy  = 1'b0;
      mon_cout  = 1'b0;
      mon_ovf   = 1'b0;
      mon_sum   = '0;
      case (sel)
         0: begin mon_valid = if_a.out_valid; mon_irdy = if_a.in_ready; mon_cout = if_a.cout; mon_ovf = if_a.ovf; mon_sum = {8'h00, if_a.sum}; end
         1: begin mon_valid = if_b.out_valid; mon_irdy = if_b.in_ready; mon_cout = if_b.cout; mon_ovf = if_b.ovf; mon_sum = {9'h000, if_b.sum}; end
         2: begin mon_valid = if_c.out_valid; mon_irdy = if_c.in_ready; mon_cout = if_c.cout; mon_ovf = if_c.ovf; mon_sum = if_c.sum; end
         3: begin mon_valid = if_d.out_valid; mon_irdy = if_d.in_ready; mon_cout = if_d.cout; mon_ovf = if_d.ovf; mon_sum = {8'h00, if_d.sum}; end
         4: begin mon_valid = if_e.out_valid; mon_irdy = if_e.in_ready; mon_cout = if_e.cout; mon_ovf = if_e.ovf; mon_sum = {12'h000, if_e.sum}; end
         default: ;
      endcase
   end

   // Whole-word reference: {cout, ovf, sum} for an n-bit add/subtract.
   function automatic logic [17:0] ref_model(input int n, input logic [15:0] a, input logic [15:0] b,
                                             input logic cin, input logic sub);
      int unsigned mask, mlo, bxv, c0v, full, low;
      logic co, cm;
      mask = (32'd1 << n) - 32'd1;
      mlo  = mask >> 1;
      bxv  = sub ? (~{16'h0000, b} & mask) : ({16'h0000, b} & mask);
      c0v  = (sub || cin) ? 32'd1 : 32'd0;
      full = ({16'h0000, a} & mask) + bxv + c0v;
      low  = ({16'h0000, a} & mlo) + (bxv & mlo) + c0v;
      co   = ((full >> n) & 32'd1) != 0;
      cm   = ((low >> (n - 1)) & 32'd1) != 0;
      return {co, cm ^ co, 16'(full & mask)};
   endfunction

   // ---------------- driver tasks ----------------
   // Offers one beat, then waits (bounded) for the result with out_ready high.
   task automatic one_beat(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                           output logic irdy, output int lat, output logic got, output logic [17:0] obs);
      @(negedge clk);
      drv_valid = 1'b1; drv_a = a; drv_b = b; drv_cin = cin; drv_sub = sub; drv_ordy = 1'b1;
      #1;
      irdy = mon_irdy;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      drv_valid = 1'b0;
      #1;
      while (!mon_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         #1;
      end
      got = mon_valid;
      obs = {mon_cout, mon_ovf, mon_sum};
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int i = 0; i < 5; i++) begin
         sel = i;
         #1;
         n_cmp++;
         if (mon_valid !== 1'b0 || mon_irdy !== 1'b1 || {mon_cout, mon_ovf, mon_sum} !== 18'h0) begin
            n_bad++;
            $display("FAIL reset_state dut=%0d valid=%b in_ready=%b res=%h want valid=0 in_ready=1 res=0",
                     i, mon_valid, mon_irdy, {mon_cout, mon_ovf, mon_sum});
         end
      end
   endtask

   task automatic test_basic();
      logic irdy, got; int lat; logic [17:0] obs, e;
      sel = 0;
      exp_q.push_back({1'b1, 1'b0, 16'h0000});
      one_beat(16'h00FF, 16'h0001, 1'b0, 1'b0, irdy, lat, got, obs);
      e = exp_q.pop_front();
      n_cmp++;
      if (irdy !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready got=%b want=1", irdy); end
      n_cmp++;
      if (got !== 1'b1 || lat != 2) begin n_bad++; $display("FAIL basic_latency got valid=%b lat=%0d want valid=1 lat=2", got, lat); end
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL basic_result got=%h want=%h", obs, e); end
   endtask

   task automatic test_subtract_overflow();
      logic irdy, got; int lat; logic [17:0] obs, e;
      sel = 0;
      exp_q.push_back({1'b0, 1'b0, 16'h00FE});
      one_beat(16'h0005, 16'h0007, 1'b1, 1'b1, irdy, lat, got, obs);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== 1'b1 || obs !== e) begin n_bad++; $display("FAIL sub_5_minus_7 got=%h valid=%b want=%h", obs, got, e); end
      exp_q.push_back({1'b0, 1'b1, 16'h0080});
      one_beat(16'h007F, 16'h0001, 1'b0, 1'b0, irdy, lat, got, obs);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== 1'b1 || obs !== e) begin n_bad++; $display("FAIL add_signed_ovf got=%h valid=%b want=%h", obs, got, e); end
   endtask

   task automatic test_non_divisible();
      logic irdy, got; int lat; logic [17:0] obs, e;
      sel = 1;
      exp_q.push_back({1'b1, 1'b0, 16'h0001});
      one_beat(16'h007F, 16'h0001, 1'b1, 1'b0, irdy, lat, got, obs);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== 1'b1 || lat != 3) begin n_bad++; $display("FAIL n7_latency got valid=%b lat=%0d want valid=1 lat=3", got, lat); end
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL n7_result got=%h want=%h", obs, e); end
   endtask

   task automatic test_degenerate();
      logic irdy, got; int lat; logic [17:0] obs, e;
      sel = 4;
      exp_q.push_back({1'b1, 1'b1, 16'h0003});
      one_beat(16'h0009, 16'h0009, 1'b1, 1'b0, irdy, lat, got, obs);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== 1'b1 || lat != 1) begin n_bad++; $display("FAIL s1_latency got valid=%b lat=%0d want valid=1 lat=1", got, lat); end
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL s1_result got=%h want=%h", obs, e); end
   endtask

   task automatic test_reset_midflight();
      logic irdy, got; int lat, stale; logic [17:0] obs, e;
      sel = 3;
      drv_ordy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drv_valid = 1'b1; drv_a = 16'(i + 1); drv_b = 16'h0003; drv_cin = 1'b0; drv_sub = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      drv_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (mon_valid !== 1'b1) begin n_bad++; $display("FAIL midflight_first_out got valid=%b want=1", mon_valid); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (mon_valid !== 1'b0 || {mon_cout, mon_ovf, mon_sum} !== 18'h0 || mon_irdy !== 1'b1) begin
         n_bad++;
         $display("FAIL midflight_reset got valid=%b res=%h in_ready=%b want valid=0 res=0 in_ready=1",
                  mon_valid, {mon_cout, mon_ovf, mon_sum}, mon_irdy);
      end
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (mon_irdy !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got=%b want=1", mon_irdy); end
      stale = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1;
         if (mon_valid) stale++;
      end
      n_cmp++;
      if (stale != 0) begin n_bad++; $display("FAIL stale_beats got=%0d want=0", stale); end
      exp_q.push_back({1'b0, 1'b0, 16'h0030});
      one_beat(16'h0010, 16'h0020, 1'b0, 1'b0, irdy, lat, got, obs);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== 1'b1 || lat != 4 || obs !== e) begin
         n_bad++;
         $display("FAIL post_reset_beat got=%h valid=%b lat=%0d want=%h lat=4", obs, got, lat, e);
      end
   endtask

   task automatic test_streaming();
      int sent, recv, cyc;
      logic have_held, acc;
      logic [17:0] held, obs, e;
      sel = 2; exp_q.delete();
      sent = 0; recv = 0; cyc = 0; have_held = 1'b0; acc = 1'b0; drv_valid = 1'b0;
      while ((sent < 200 || recv < sent) && cyc < 5000) begin
         @(negedge clk);
         if (acc) drv_valid = 1'b0;
         acc = 1'b0;
         if (!drv_valid && sent < 200 && $urandom_range(0, 3) != 0) begin
            drv_valid = 1'b1;
            drv_a   = 16'($urandom);
            drv_b   = 16'($urandom);
            drv_cin = 1'($urandom_range(0, 1));
            drv_sub = 1'($urandom_range(0, 1));
         end
         drv_ordy = ($urandom_range(0, 2) != 0);
         #1;
         obs = {mon_cout, mon_ovf, mon_sum};
         if (have_held) begin
            n_cmp++;
            if (mon_valid !== 1'b1 || obs !== held) begin
               n_bad++;
               $display("FAIL stall_hold got valid=%b res=%h want valid=1 res=%h", mon_valid, obs, held);
            end
         end
         have_held = 1'b0;
         if (mon_valid) begin
            if (drv_ordy) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL stream_extra got=%h want=none", obs);
               end else begin
                  e = exp_q.pop_front();
                  if (obs !== e) begin n_bad++; $display("FAIL stream_result idx=%0d got=%h want=%h", recv, obs, e); end
               end
               recv++;
            end else begin
               held = obs;
               have_held = 1'b1;
            end
         end
         if (drv_valid && mon_irdy) begin
            exp_q.push_back(ref_model(16, drv_a, drv_b, drv_cin, drv_sub));
            sent++;
            acc = 1'b1;
         end
         @(posedge clk);
         cyc++;
      end
      @(negedge clk);
      drv_valid = 1'b0; drv_ordy = 1'b1;
      n_cmp++;
      if (cyc >= 5000 || recv != 200 || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL stream_count got recv=%0d left=%0d cycles=%0d want recv=200 left=0", recv, exp_q.size(), cyc);
      end
   endtask

   task automatic test_back_to_back();
      int recv, first_out, last_out;
      logic [17:0] obs, e;
      sel = 2; exp_q.delete(); drv_ordy = 1'b1;
      recv = 0; first_out = -1; last_out = -1;
      for (int c = 0; c < 26; c++) begin
         @(negedge clk);
         if (c < 20) begin
            drv_valid = 1'b1;
            drv_a = 16'($urandom); drv_b = 16'($urandom);
            drv_cin = 1'($urandom_range(0, 1)); drv_sub = 1'($urandom_range(0, 1));
         end else begin
            drv_valid = 1'b0;
         end
         #1;
         obs = {mon_cout, mon_ovf, mon_sum};
         if (mon_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL b2b_extra got=%h want=none", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin n_bad++; $display("FAIL b2b_result idx=%0d got=%h want=%h", recv, obs, e); end
            end
            if (first_out < 0) first_out = c;
            last_out = c;
            recv++;
         end
         if (c < 20) begin
            n_cmp++;
            if (mon_irdy !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready cycle=%0d got=%b want=1", c, mon_irdy); end
            exp_q.push_back(ref_model(16, drv_a, drv_b, drv_cin, drv_sub));
         end
         @(posedge clk);
      end
      n_cmp++;
      if (recv != 20 || first_out != 4 || last_out != 23) begin
         n_bad++;
         $display("FAIL b2b_rate got recv=%0d first=%0d last=%0d want recv=20 first=4 last=23", recv, first_out, last_out);
      end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      rst_n = 1'b0; sel = 0;
      drv_valid = 1'b0; drv_cin = 1'b0; drv_sub = 1'b0; drv_ordy = 1'b1;
      drv_a = '0; drv_b = '0;
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_basic();
      test_subtract_overflow();
      test_non_divisible();
      test_degenerate();
      test_reset_midflight();
      test_streaming();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
